// File: rtl/rtst32_pkg.sv
// rtst32_pkg: constants shared by the shift-right-logical unit.
//   WIDTH   operand / result width (fixed at 32)
//   SHW     shift-amount field width, log2(WIDTH)
//   alu_op_e  ALU opcode set; the result mux selects the rtst32 output on ALU_SRL.
package rtst32_pkg;

  localparam int WIDTH = 32;
  localparam int SHW   = 5;

  typedef enum logic [3:0] {
    ALU_ADD = 4'h0,
    ALU_SUB = 4'h1,
    ALU_AND = 4'h2,
    ALU_OR  = 4'h3,
    ALU_XOR = 4'h4,
    ALU_SLL = 4'h5,
    ALU_SRL = 4'h6,
    ALU_SRA = 4'h7
  } alu_op_e;

endpackage : rtst32_pkg

// File: rtl/rtst32_stage.sv
// rtst32_stage: one combinational barrel-shifter stage.
//   SH  fixed shift distance of this stage
//   d   stage input
//   en  apply the shift when 1, pass d through when 0
//   q   d >> SH (zero fill) when en, else d
module rtst32_stage
  import rtst32_pkg::*;
#(
  parameter int SH = 1
) (
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  assign q = en ? (d >> SH) : d;

endmodule : rtst32_stage

// File: rtl/rtst32.sv
// rtst32: 32-bit registered logical right shifter (ALU SRL unit).
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   A/B sampled this cycle
//   A          value to shift (unsigned)
//   B          shift amount (unsigned, all 32 bits significant)
//   out_valid  C holds a new result (in_valid delayed one cycle)
//   C          registered A >> B; holds while in_valid is low
module rtst32
  import rtst32_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  output logic [WIDTH-1:0] C
);

  // chain[0] is the raw operand; chain[k+1] is the output of stage k.
  logic [SHW:0][WIDTH-1:0] chain;
  logic                    overflow;
  logic [WIDTH-1:0]        c_d, c_q;
  logic                    out_valid_d, out_valid_q;

  assign chain[0] = A;

  generate
    for (genvar gi = 0; gi < SHW; gi++) begin : g_stage
      rtst32_stage #(
        .SH (1 << gi)
      ) u_stage (
        .d  (chain[gi]),
        .en (B[gi]),
        .q  (chain[gi+1])
      );
    end
  endgenerate

  // Any shift amount of WIDTH or more empties the word; it is never taken modulo WIDTH.
  assign overflow = |B[WIDTH-1:SHW];

  always_comb begin
    c_d         = c_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      c_d = overflow ? '0 : chain[SHW];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      c_q         <= c_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign C         = c_q;
  assign out_valid = out_valid_q;

endmodule : rtst32

// File: tb/tb_rtst32.sv
// tb_rtst32: directed and randomized checks of rtst32 against a plain
// arithmetic reference (C = B > 31 ? 0 : A >> B, one-cycle latency, hold on idle).
module tb_rtst32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        out_valid;
  logic [31:0] C;

  int checks = 0;
  int errors = 0;

  // reference state
  logic [31:0] exp_c = '0;
  logic        exp_v = 1'b0;

  rtst32 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .C         (C)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_srl(input logic [31:0] a, input logic [31:0] b);
    if (b > 32'd31) return 32'h0;
    return a >> b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle on the falling edge, update the model at the rising edge,
  // then sample the DUT 1 time unit later.
  task automatic step(input logic r, input logic v, input logic [31:0] a,
                      input logic [31:0] b, input string tag);
    @(negedge clk);
    rst = r; in_valid = v; A = a; B = b;
    @(posedge clk);
    if (r) begin
      exp_c = 32'h0;
      exp_v = 1'b0;
    end else begin
      if (v) exp_c = ref_srl(a, b);
      exp_v = v;
    end
    #1;
    chk({tag, ".C"}, C, exp_c);
    chk({tag, ".out_valid"}, {31'b0, out_valid}, {31'b0, exp_v});
    $display("step %s rst=%0b v=%0b A=%h B=%h -> C=%h out_valid=%0b",
             tag, r, v, a, b, C, out_valid);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rv;

    // reset state
    step(1'b1, 1'b0, 32'h0, 32'h0, "reset0");
    step(1'b1, 1'b1, 32'h12345678, 32'h1, "reset1");

    // nominal
    step(1'b0, 1'b1, 32'h00C0EC4E, 32'd5, "nominal");
    chk("nominal.lit", C, 32'h00060762);

    // boundaries: zero fill, no sign extension
    step(1'b0, 1'b1, 32'h80000000, 32'd0, "b0");
    chk("b0.lit", C, 32'h80000000);
    step(1'b0, 1'b1, 32'h80000000, 32'd1, "b1");
    chk("b1.lit", C, 32'h40000000);
    step(1'b0, 1'b1, 32'h80000000, 32'd31, "b31");
    chk("b31.lit", C, 32'h00000001);

    // overflow
    step(1'b0, 1'b1, 32'hFFFFFFFF, 32'd32, "ovf32");
    chk("ovf32.lit", C, 32'h0);
    step(1'b0, 1'b1, 32'hFFFFFFFF, 32'h00000100, "ovf256");
    chk("ovf256.lit", C, 32'h0);
    step(1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, "ovfmax");
    chk("ovfmax.lit", C, 32'h0);

    // streaming then hold
    step(1'b0, 1'b1, 32'hF0F0F0F0, 32'd4, "stream4");
    chk("stream4.lit", C, 32'h0F0F0F0F);
    step(1'b0, 1'b1, 32'hF0F0F0F0, 32'd8, "stream8");
    chk("stream8.lit", C, 32'h00F0F0F0);
    step(1'b0, 1'b1, 32'hF0F0F0F0, 32'd12, "stream12");
    chk("stream12.lit", C, 32'h000F0F0F);
    step(1'b0, 1'b1, 32'hF0F0F0F0, 32'd16, "stream16");
    chk("stream16.lit", C, 32'h0000F0F0);
    step(1'b0, 1'b0, 32'hDEADBEEF, 32'd3, "hold");
    chk("hold.lit", C, 32'h0000F0F0);
    chk("hold.vlit", {31'b0, out_valid}, 32'h0);

    // reset mid-stream beats in_valid
    step(1'b0, 1'b1, 32'h12345678, 32'd4, "prerst");
    step(1'b1, 1'b1, 32'hFFFFFFFF, 32'd1, "midrst");
    chk("midrst.lit", C, 32'h0);
    step(1'b0, 1'b1, 32'hFFFFFFFF, 32'd1, "resume");
    chk("resume.lit", C, 32'h7FFFFFFF);

    // randomized, B biased to 0..40, occasional idle cycles and wide B
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 9) == 0) ? $urandom : $urandom_range(0, 40);
      rv = ($urandom_range(0, 9) != 0);
      step(1'b0, rv, ra, rb, $sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_rtst32
